// File: rtl/reset_sequencer.sv
// Staged reset release: memory, then register file, then CPU core, then sys_ready.
// A soft-reset handshake re-sequences the register file and core while memory stays up.
module reset_sequencer #(
    parameter int unsigned STAGE_CYCLES    = 16,
    parameter int unsigned SOFT_RST_CYCLES = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       soft_rst_req,
    output logic       soft_rst_ack,
    output logic       mem_rst_n,
    output logic       reg_rst_n,
    output logic       core_rst_n,
    output logic       sys_ready,
    output logic [2:0] stage
);

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_MEM  = 3'd1,
        WAIT_REG  = 3'd2,
        WAIT_CORE = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_RST_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             armed, armed_nx;
    logic             mem_nx, reg_nx, core_nx, ready_nx, ack_nx;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= RESET;
            cnt          <= '0;
            armed        <= 1'b0;
            mem_rst_n    <= 1'b0;
            reg_rst_n    <= 1'b0;
            core_rst_n   <= 1'b0;
            sys_ready    <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            armed        <= armed_nx;
            mem_rst_n    <= mem_nx;
            reg_rst_n    <= reg_nx;
            core_rst_n   <= core_nx;
            sys_ready    <= ready_nx;
            soft_rst_ack <= ack_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mem_nx   = mem_rst_n;
        reg_nx   = reg_rst_n;
        core_nx  = core_rst_n;
        ready_nx = sys_ready;
        ack_nx   = 1'b0;
        // A low sample re-arms in every state; only an acceptance disarms.
        armed_nx = soft_rst_req ? armed : 1'b1;
        case (state)
            RESET: begin
                state_nx = WAIT_MEM;
                cnt_nx   = '0;
                mem_nx   = 1'b0;
                reg_nx   = 1'b0;
                core_nx  = 1'b0;
                ready_nx = 1'b0;
            end
            WAIT_MEM: begin
                if (cnt == STAGE_LAST) begin
                    mem_nx   = 1'b1;
                    state_nx = WAIT_REG;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_REG: begin
                if (cnt == STAGE_LAST) begin
                    reg_nx   = 1'b1;
                    state_nx = WAIT_CORE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_CORE: begin
                if (cnt == STAGE_LAST) begin
                    core_nx  = 1'b1;
                    ready_nx = 1'b1;
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                if (soft_rst_req && armed) begin
                    state_nx = SOFT;
                    reg_nx   = 1'b0;
                    core_nx  = 1'b0;
                    ready_nx = 1'b0;
                    ack_nx   = 1'b1;
                    armed_nx = 1'b0;
                    cnt_nx   = '0;
                end
            end
            SOFT: begin
                if (cnt == SOFT_LAST) begin
                    state_nx = WAIT_REG;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = RESET;
                cnt_nx   = '0;
                mem_nx   = 1'b0;
                reg_nx   = 1'b0;
                core_nx  = 1'b0;
                ready_nx = 1'b0;
            end
        endcase
    end

    assign stage = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus a minimum-parameter instance.
module tb_reset_sequencer;

    localparam int S  = 16;
    localparam int SR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0, req = 1'b0;
    logic       ack, mem, regn, core, ready;
    logic [2:0] stage;
    logic       rst_m = 1'b0, req_m = 1'b0;
    logic       ack_m, mem_m, regn_m, core_m, ready_m;
    logic [2:0] stage_m;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_v;
    logic [7:0] obs, obs_m;

    reset_sequencer #(.STAGE_CYCLES(S), .SOFT_RST_CYCLES(SR), .CNT_W(8)) dut (
        .sys_clk(clk), .rst(rst), .soft_rst_req(req), .soft_rst_ack(ack),
        .mem_rst_n(mem), .reg_rst_n(regn), .core_rst_n(core), .sys_ready(ready), .stage(stage)
    );

    reset_sequencer #(.STAGE_CYCLES(1), .SOFT_RST_CYCLES(1), .CNT_W(8)) dut_min (
        .sys_clk(clk), .rst(rst_m), .soft_rst_req(req_m), .soft_rst_ack(ack_m),
        .mem_rst_n(mem_m), .reg_rst_n(regn_m), .core_rst_n(core_m), .sys_ready(ready_m),
        .stage(stage_m)
    );

    always #5 clk = ~clk;

    assign obs   = {mem, regn, core, ready, ack, stage};
    assign obs_m = {mem_m, regn_m, core_m, ready_m, ack_m, stage_m};

    // Expected {mem,reg,core,ready,ack,stage} after power-up edge e (edge 1 = first with rst low).
    function automatic logic [7:0] exp_pu(int e, int s);
        logic       m, r, c;
        logic [2:0] st;
        m = (e >= s + 1);
        r = (e >= 2 * s + 1);
        c = (e >= 3 * s + 1);
        if (e <= 0)  st = 3'd0;
        else if (c)  st = 3'd4;
        else if (r)  st = 3'd3;
        else if (m)  st = 3'd2;
        else         st = 3'd1;
        return {m, r, c, c, 1'b0, st};
    endfunction

    // Expected vector k edges after a soft reset accepted at edge t (k=0 is edge t).
    function automatic logic [7:0] exp_soft(int k, int s, int sr);
        logic       r, c;
        logic [2:0] st;
        r = (k >= sr + s);
        c = (k >= sr + 2 * s);
        if (c)            st = 3'd4;
        else if (r)       st = 3'd3;
        else if (k >= sr) st = 3'd2;
        else              st = 3'd5;
        return {1'b1, r, c, c, (k == 0), st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1; rst_m = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", obs, 8'h00);
        end
        repeat (3) tick();
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", obs, 8'h00);
        end
        n_checks++;
        if (obs_m !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold_min: got %b expected %b", obs_m, 8'h00);
        end
    endtask

    task automatic test_powerup();
        req = 1'b0;
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        for (int e = 1; e <= 3 * S + 3; e++) sb.push_back(exp_pu(e, S));
        for (int e = 1; e <= 3 * S + 3; e++) begin
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL powerup edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_soft_reset();
        req = 1'b1;
        for (int k = 0; k <= SR + 2 * S + 2; k++) sb.push_back(exp_soft(k, S, SR));
        for (int k = 0; k <= SR + 2 * S + 2; k++) begin
            tick();
            if (k == 2) req = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL soft k=%0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_held_request();
        req = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int e = 1; e <= 3 * S + 5; e++) sb.push_back(exp_pu(e, S));
        for (int e = 1; e <= 3 * S + 5; e++) begin
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL held edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
        req = 1'b0;
        sb.push_back(exp_pu(3 * S + 6, S));
        tick();
        exp_v = sb.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL held_drop: got %b expected %b", obs, exp_v);
        end
        req = 1'b1;
        for (int k = 0; k <= SR + 2 * S + 1; k++) sb.push_back(exp_soft(k, S, SR));
        for (int k = 0; k <= SR + 2 * S + 1; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL held_soft k=%0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int e = 1; e <= S + 8; e++) sb.push_back(exp_pu(e, S));
        for (int e = 1; e <= S + 8; e++) begin
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_pre edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_wait_reg_async: got %b expected %b", obs, 8'h00);
        end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 3 * S + 2; e++) sb.push_back(exp_pu(e, S));
        for (int e = 1; e <= 3 * S + 2; e++) begin
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_repeat edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
        req = 1'b1;
        for (int k = 0; k <= 3; k++) sb.push_back(exp_soft(k, S, SR));
        for (int k = 0; k <= 3; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_soft k=%0d: got %b expected %b", k, obs, exp_v);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_soft_async: got %b expected %b", obs, 8'h00);
        end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 3 * S + 2; e++) sb.push_back(exp_pu(e, S));
        for (int e = 1; e <= 3 * S + 2; e++) begin
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_repeat2 edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_min_params();
        req_m = 1'b0;
        rst_m = 1'b1;
        tick();
        n_checks++;
        if (obs_m !== 8'h00) begin
            n_fail++;
            $display("FAIL min_reset: got %b expected %b", obs_m, 8'h00);
        end
        rst_m = 1'b0;
        for (int e = 1; e <= 6; e++) sb.push_back(exp_pu(e, 1));
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_m !== exp_v) begin
                n_fail++;
                $display("FAIL min_pu edge %0d: got %b expected %b", e, obs_m, exp_v);
            end
        end
        req_m = 1'b1;
        for (int k = 0; k <= 5; k++) sb.push_back(exp_soft(k, 1, 1));
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k == 0) req_m = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_m !== exp_v) begin
                n_fail++;
                $display("FAIL min_soft k=%0d: got %b expected %b", k, obs_m, exp_v);
            end
        end
    endtask

    task automatic test_req_outside_run();
        req = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int e = 1; e <= 3 * S + 3; e++) sb.push_back(exp_pu(e, S));
        for (int e = 1; e <= 3 * S + 3; e++) begin
            if (e == 4)  req = 1'b1;
            if (e == 11) req = 1'b0;
            tick();
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL outside edge %0d: got %b expected %b", e, obs, exp_v);
            end
        end
        req = 1'b1;
        for (int k = 0; k <= SR + 2 * S + 1; k++) sb.push_back(exp_soft(k, S, SR));
        for (int k = 0; k <= SR + 2 * S + 1; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL outside_soft k=%0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_soft_reset();
        test_held_request();
        test_reset_mid();
        test_min_params();
        test_req_outside_run();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
